// File: rtl/mc_pkg.sv
// mc_pkg: shared constants for the multicycle control unit.
//   - state_t    : FSM state encoding
//   - OP_*/F3_*  : opcode and funct3 encodings recognised by the decoder
//   - ALU_*      : ALU operation codes driven on alu_control
//   - SRC_B_*    : ALU B operand selects
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_BNE = 4'b0100;

  localparam logic [1:0] SRC_B_REG  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: purely combinational instruction decoder.
//   in : opcode[6:0], funct3[2:0], funct7_5
//   out: alu_control[3:0] (operation used in EXEC), illegal (unsupported encoding)
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_control,
  output logic       illegal
);

  // Everything is illegal unless a supported encoding matches below.
  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b1;
    case (opcode)
      OP_R: begin
        case (funct3)
          F3_ADD: if (!funct7_5) begin alu_control = ALU_ADD; illegal = 1'b0; end
          F3_OR:  begin alu_control = ALU_OR;  illegal = 1'b0; end
          F3_SLL: begin alu_control = ALU_SLL; illegal = 1'b0; end
          default: ;
        endcase
      end
      OP_I: begin
        case (funct3)
          F3_ADD: begin alu_control = ALU_ADD; illegal = 1'b0; end
          F3_OR:  begin alu_control = ALU_OR;  illegal = 1'b0; end
          F3_AND: begin alu_control = ALU_AND; illegal = 1'b0; end
          default: ;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        if (funct3 == F3_WORD) begin alu_control = ALU_ADD; illegal = 1'b0; end
      end
      OP_BRANCH: begin
        if (funct3 == F3_BNE) begin alu_control = ALU_BNE; illegal = 1'b0; end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle RISC-V-subset control unit.
//   in : clk, rst_n (async active-low), opcode/funct3/funct7_5 (from IR),
//        alu_zero, mem_ready
//   out: mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
//        reg_write, mem_to_reg, alu_src_b[1:0], alu_control[3:0],
//        halted, illegal, instret[31:0]
// Optional feature: define MC_CONTROL_INSTRET_EN to build the saturating
// retired-instruction counter; otherwise instret is tied to 0.
// Outputs are decoded from the state register (plus alu_zero in a branch
// EXEC and mem_ready for the fetch write pulses) and forced to 0 while
// rst_n is low, so a reset mid-access drops mem_req without a clock edge.
module mc_control
  import mc_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alu_src_a,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_control,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam int unsigned WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              trap_illegal;
  logic [3:0]        dec_alu;
  logic              dec_illegal;
  logic              is_load;
  logic              is_store;
  logic              is_branch;
  logic              is_r;
  logic              wait_expired;

  mc_alu_decoder u_dec (
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_control (dec_alu),
    .illegal     (dec_illegal)
  );

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_r      = (opcode == OP_R);

  // True when this wait cycle would be the MEM_WAIT_MAX-th without mem_ready.
  assign wait_expired = ((32'(wait_cnt) + 32'd1) >= 32'(MEM_WAIT_MAX));

  // State, wait counter and trap cause. The counter clears on every
  // transition and only counts while stalled in FETCH or MEM; mem_ready
  // wins over an expiring counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_FETCH;
      wait_cnt     <= '0;
      trap_illegal <= 1'b0;
    end else begin
      wait_cnt <= '0;
      case (state)
        ST_FETCH: begin
          if (mem_ready)         state <= ST_DECODE;
          else if (wait_expired) state <= ST_TRAP;
          else                   wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        ST_DECODE: begin
          if (dec_illegal) begin
            state        <= ST_TRAP;
            trap_illegal <= 1'b1;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_load || is_store) state <= ST_MEM;
          else if (is_branch)      state <= ST_FETCH;
          else                     state <= ST_WB;
        end
        ST_MEM: begin
          if (mem_ready)         state <= is_store ? ST_FETCH : ST_WB;
          else if (wait_expired) state <= ST_TRAP;
          else                   wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        ST_WB:   state <= ST_FETCH;
        ST_TRAP: state <= ST_TRAP;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Output decode; everything stays 0 while reset is asserted.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    alu_src_a   = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_b   = SRC_B_REG;
    alu_control = ALU_ADD;
    halted      = 1'b0;
    illegal     = 1'b0;
    if (rst_n) begin
      case (state)
        ST_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRC_B_FOUR;
          // IR and PC update only on the completing cycle of the fetch.
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        ST_DECODE: alu_src_b = SRC_B_IMM;
        ST_EXEC: begin
          alu_src_a   = 1'b1;
          alu_control = dec_alu;
          if (is_branch) begin
            alu_src_b = SRC_B_REG;
            pc_write  = !alu_zero;
            pc_src    = 1'b1;
          end else if (is_r) begin
            alu_src_b = SRC_B_REG;
          end else begin
            alu_src_b = SRC_B_IMM;
          end
        end
        ST_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = is_store;
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = is_load;
        end
        ST_TRAP: begin
          halted  = 1'b1;
          illegal = trap_illegal;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_CONTROL_INSTRET_EN
  logic        retire;
  logic [31:0] instret_q;

  // An instruction retires on its final transition back into FETCH.
  assign retire = (state == ST_WB)
               || ((state == ST_EXEC) && is_branch)
               || ((state == ST_MEM) && is_store && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          instret_q <= '0;
    else if (retire && (instret_q != '1)) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized self-checking bench for mc_control. Each
// instruction is expanded into its expected per-cycle output vectors from
// the instruction-class rules, then driven and compared cycle by cycle.
module tb_mc_control;

  localparam int unsigned MAXW = 15;

  localparam logic [6:0] T_R = 7'b0110011, T_I = 7'b0010011, T_LD = 7'b0000011;
  localparam logic [6:0] T_ST = 7'b0100011, T_BR = 7'b1100011;

  // Output vector bit positions.
  localparam logic [16:0] B_MREQ = 17'h10000, B_MWE  = 17'h08000, B_IORD = 17'h04000;
  localparam logic [16:0] B_IRW  = 17'h02000, B_PCW  = 17'h01000, B_PCSRC = 17'h00800;
  localparam logic [16:0] B_SRCA = 17'h00400, B_REGW = 17'h00200, B_MTR  = 17'h00100;
  localparam logic [16:0] F_SRCB = 17'h000C0, F_ALUC = 17'h0003C;
  localparam logic [16:0] B_HALT = 17'h00002, B_ILL  = 17'h00001;
  localparam logic [16:0] M_EN = B_MREQ | B_MWE | B_IRW | B_PCW | B_REGW | B_HALT | B_ILL;

  logic        clk, rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5, alu_zero, mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
  logic        reg_write, mem_to_reg, halted, illegal;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_control;
  logic [31:0] instret;
  logic [16:0] out_vec;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned retired = 0;

  mc_control #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .halted(halted),
    .illegal(illegal), .instret(instret)
  );

  assign out_vec = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                    reg_write, mem_to_reg, alu_src_b, alu_control, halted, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] srcb(input logic [1:0] v);
    return 17'(v) << 6;
  endfunction

  function automatic logic [16:0] aluc(input logic [3:0] v);
    return 17'(v) << 2;
  endfunction

  // Reference decode: {legal, alu op} from the supported-encoding list.
  function automatic logic [4:0] ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                            input logic f7);
    logic [4:0] r;
    r = 5'h00;
    if (op == T_R  && f3 == 3'b000 && !f7) r = {1'b1, 4'h0};
    if (op == T_R  && f3 == 3'b110)        r = {1'b1, 4'h1};
    if (op == T_R  && f3 == 3'b001)        r = {1'b1, 4'h3};
    if (op == T_I  && f3 == 3'b000)        r = {1'b1, 4'h0};
    if (op == T_I  && f3 == 3'b110)        r = {1'b1, 4'h1};
    if (op == T_I  && f3 == 3'b111)        r = {1'b1, 4'h2};
    if (op == T_LD && f3 == 3'b010)        r = {1'b1, 4'h0};
    if (op == T_ST && f3 == 3'b010)        r = {1'b1, 4'h0};
    if (op == T_BR && f3 == 3'b001)        r = {1'b1, 4'h4};
    return r;
  endfunction

  function automatic logic [31:0] exp_instret();
`ifdef MC_CONTROL_INSTRET_EN
    return retired;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Entered at a falling edge: drive mem_ready, compare, advance to next falling edge.
  task automatic step(input string tag, input logic rdy, input logic [16:0] ev,
                      input logic [16:0] m);
    mem_ready = rdy;
    #1;
    check(tag, 32'(out_vec & m), 32'(ev & m));
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("reset_outs", 32'(out_vec), 32'd0);
    check("reset_instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    retired = 0;
  endtask

  task automatic trap_cycles(input logic ill, input int n);
    for (int i = 0; i < n; i++)
      step(ill ? "trap_illegal" : "trap_timeout", 1'($urandom),
           B_HALT | (ill ? B_ILL : 17'h0), M_EN);
    apply_reset();
  endtask

  // One instruction from FETCH back to FETCH (or into TRAP then reset).
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int fw, input int mw, input logic az);
    logic [4:0] d;
    logic       ld, st, br, rr;
    logic [16:0] m_fetch;
    d  = ref_decode(op, f3, f7);
    ld = (op == T_LD);
    st = (op == T_ST);
    br = (op == T_BR);
    rr = (op == T_R);
    opcode = op; funct3 = f3; funct7_5 = f7; alu_zero = az;
    m_fetch = M_EN | B_IORD | B_SRCA | F_SRCB | F_ALUC;
    check("instret", instret, exp_instret());
    for (int w = 0; w < fw; w++)
      step("fetch_wait", 1'b0, B_MREQ | srcb(2'd1), m_fetch & ~(B_IRW | B_PCW));
    if (fw >= int'(MAXW)) begin
      trap_cycles(1'b0, 5);
      return;
    end
    step("fetch", 1'b1, B_MREQ | B_IRW | B_PCW | srcb(2'd1), m_fetch);
    step("decode", 1'($urandom), srcb(2'd2), M_EN | B_SRCA | F_SRCB | F_ALUC);
    if (!d[4]) begin
      trap_cycles(1'b1, 20);
      return;
    end
    if (br) begin
      step("exec_bne", 1'($urandom), B_PCSRC | B_SRCA | srcb(2'd0) | aluc(4'h4) |
           (az ? 17'h0 : B_PCW), M_EN | B_PCSRC | B_SRCA | F_SRCB | F_ALUC);
      retired++;
      return;
    end
    step("exec", 1'($urandom), srcb(rr ? 2'd0 : 2'd2) | aluc(d[3:0]),
         M_EN | F_SRCB | F_ALUC);
    if (ld || st) begin
      for (int w = 0; w < mw; w++)
        step("mem_wait", 1'b0, B_MREQ | B_IORD | (st ? B_MWE : 17'h0), M_EN | B_IORD);
      if (mw >= int'(MAXW)) begin
        trap_cycles(1'b0, 5);
        return;
      end
      step("mem", 1'b1, B_MREQ | B_IORD | (st ? B_MWE : 17'h0), M_EN | B_IORD);
      if (st) begin
        retired++;
        return;
      end
    end
    step("wb", 1'($urandom), B_REGW | (ld ? B_MTR : 17'h0), M_EN | B_MTR);
    retired++;
  endtask

  // Store interrupted by reset while waiting in MEM.
  task automatic store_reset_test();
    opcode = T_ST; funct3 = 3'b010; funct7_5 = 1'b0;
    step("sr_fetch", 1'b1, B_MREQ | B_IRW | B_PCW | srcb(2'd1), M_EN | B_IORD);
    step("sr_decode", 1'b0, srcb(2'd2), M_EN | F_SRCB);
    step("sr_exec", 1'b0, srcb(2'd2) | aluc(4'h0), M_EN | F_SRCB | F_ALUC);
    mem_ready = 1'b0;
    #1;
    check("sr_mem_active", 32'({mem_req, mem_we, iord}), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("sr_async_drop", 32'(out_vec), 32'd0);
    check("sr_instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    retired = 0;
  endtask

  task automatic rand_legal(output logic [6:0] op, output logic [2:0] f3, output logic f7);
    logic [2:0] r3[3];
    f7 = 1'($urandom);
    case ($urandom_range(0, 4))
      0: begin op = T_R; r3 = '{3'b000, 3'b110, 3'b001}; f3 = r3[$urandom_range(0, 2)]; f7 = 1'b0; end
      1: begin op = T_I; r3 = '{3'b000, 3'b110, 3'b111}; f3 = r3[$urandom_range(0, 2)]; end
      2: begin op = T_LD; f3 = 3'b010; end
      3: begin op = T_ST; f3 = 3'b010; end
      default: begin op = T_BR; f3 = 3'b001; end
    endcase
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [6:0] ops[5];
    ops = '{T_R, T_I, T_LD, T_ST, T_BR};
    rst_n = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0;
    opcode = 7'h0; funct3 = 3'h0; funct7_5 = 1'b0;
    #1;
    check("por_outs", 32'(out_vec), 32'd0);
    check("por_instret", instret, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(T_R, 3'b000, 1'b0, 0, 0, 1'b0);        // add
    run_instr(T_BR, 3'b001, 1'b0, 0, 0, 1'b0);       // bne taken
    run_instr(T_BR, 3'b001, 1'b0, 0, 0, 1'b1);       // bne not taken
    run_instr(T_LD, 3'b010, 1'b0, 0, 3, 1'b0);       // lw, 3 wait cycles
    run_instr(T_ST, 3'b010, 1'b0, 0, 0, 1'b0);       // sw
    run_instr(T_I, 3'b111, 1'b1, 14, 0, 1'b0);       // ready on the limit cycle
    run_instr(T_LD, 3'b010, 1'b0, 2, 14, 1'b1);

    for (int i = 0; i < 40; i++) begin
      rand_legal(op, f3, f7);
      run_instr(op, f3, f7, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    store_reset_test();
    run_instr(T_R, 3'b110, 1'b0, 0, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      op = ($urandom_range(0, 1) == 0) ? 7'($urandom) : ops[$urandom_range(0, 4)];
      run_instr(op, 3'($urandom), 1'($urandom), $urandom_range(0, 2), 0, 1'($urandom));
    end

    run_instr(T_R, 3'b000, 1'b1, 0, 0, 1'b0);        // sub -> illegal trap
    run_instr(T_I, 3'b000, 1'b0, MAXW, 0, 1'b0);     // fetch timeout
    run_instr(T_ST, 3'b010, 1'b0, 0, MAXW, 1'b0);    // mem timeout
    run_instr(T_R, 3'b001, 1'b0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
